uart_tx_stream: RTL and testbench

//  Consumer end of the byte+strobe stream produced by the register-mux processing block.

---
 rtl/uart_tx_stream.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_stream.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// Byte+strobe stream sink: small FIFO feeding an 8N1 UART serialiser (LSB first).
// Bytes strobed while the FIFO is full are dropped and flagged with a one-cycle overflow pulse.
module uart_tx_stream #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  input  logic       in_stb,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BCNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W        = PTR_W + 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [7:0]          mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                push, pop;

  // Next-state logic for FIFO bookkeeping, serialiser FSM and registered outputs
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_d      = tx_q;

    // Full is judged on the start-of-cycle count, so a same-cycle pop never rescues a push
    push  = in_stb && (count_q != CNT_FULL);
    pop   = (state_q == IDLE) && (count_q != {CNT_W{1'b0}});
    ovf_d = in_stb && (count_q == CNT_FULL);

    if (push) begin
      mem_d[wr_ptr_q] = in_byte;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        bcnt_d    = {BCNT_W{1'b0}};
        bit_idx_d = 3'd0;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d    = {BCNT_W{1'b0}};
          bit_idx_d = 3'd0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      DATA: begin
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d  = {BCNT_W{1'b0}};
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d  = {BCNT_W{1'b0}};
          state_d = IDLE;
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        bcnt_d  = {BCNT_W{1'b0}};
      end
    endcase

    busy_d = (state_d != IDLE) || (count_d != {CNT_W{1'b0}});
    full_d = (count_d == CNT_FULL);
  end

  // State and output registers; reset aborts any frame and empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bcnt_q    <= {BCNT_W{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign fifo_full = full_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at CLKS_PER_BIT=10, FIFO_DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_byte;
  logic       in_stb;
  logic       tx, busy, fifo_full, overflow;
  int         vectors = 0;
  int         miscompares = 0;

  uart_tx_stream #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_stb(in_stb),
    .tx(tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the cycle the start bit should appear; returns in the cycle after the stop bit.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [9:0] pat;
    logic [7:0] dec;
    pat = {1'b1, b, 1'b0};
    dec = 8'h00;
    for (int i = 0; i < 100; i++) begin
      if ((i % 10) == 5 && i >= 10 && i < 90) dec[i / 10 - 1] = tx;
      chk({tag, "_line"}, {7'd0, tx}, {7'd0, pat[i / 10]});
      tick();
    end
    chk({tag, "_decode"}, dec, b);
  endtask

  task automatic gap(input string tag);
    chk({tag, "_gap_tx"}, {7'd0, tx}, 8'd1);
    chk({tag, "_gap_busy"}, {7'd0, busy}, 8'd1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_stb = 1'b0;
    in_byte = 8'h00;
    repeat (3) tick();
    chk("rst_tx", {7'd0, tx}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_full", {7'd0, fifo_full}, 8'd0);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);
    rst = 1'b0;

    // 1: idle line
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_tx", {7'd0, tx}, 8'd1);
      chk("idle_busy", {7'd0, busy}, 8'd0);
      chk("idle_full", {7'd0, fifo_full}, 8'd0);
      chk("idle_ovf", {7'd0, overflow}, 8'd0);
    end

    // 2: single byte, two-cycle latency to start bit
    in_stb = 1'b1; in_byte = 8'hA5;
    tick();
    in_stb = 1'b0; in_byte = 8'h00;
    chk("t2_lat_tx", {7'd0, tx}, 8'd1);
    chk("t2_lat_busy", {7'd0, busy}, 8'd1);
    tick();
    check_frame(8'hA5, "t2");
    chk("t2_end_tx", {7'd0, tx}, 8'd1);
    chk("t2_end_busy", {7'd0, busy}, 8'd0);

    // 3: six strobes, fifth fills the FIFO, sixth overflows
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          in_stb = 1'b1; in_byte = 8'(k + 1);
          if (k == 4) chk("t3_notfull", {7'd0, fifo_full}, 8'd0);
          if (k == 5) begin
            chk("t3_full", {7'd0, fifo_full}, 8'd1);
            chk("t3_ovf_pre", {7'd0, overflow}, 8'd0);
          end
          tick();
        end
        in_stb = 1'b0;
        chk("t3_ovf_pulse", {7'd0, overflow}, 8'd1);
        tick();
        chk("t3_ovf_clear", {7'd0, overflow}, 8'd0);
      end
      begin
        tick(); tick();
        for (int k = 1; k <= 5; k++) begin
          check_frame(8'(k), "t3");
          if (k < 5) gap("t3");
        end
        chk("t3_end_busy", {7'd0, busy}, 8'd0);
      end
    join

    // 4: push on the pop cycle with count=2, then two more pushes must just fill it
    fork
      begin
        in_stb = 1'b1; in_byte = 8'h11; tick();
        in_byte = 8'h22; tick();
        in_byte = 8'h33; tick();
        in_stb = 1'b0;
        repeat (99) tick();
        in_stb = 1'b1; in_byte = 8'h3C;
        chk("t4_ovf_a", {7'd0, overflow}, 8'd0);
        tick();
        in_byte = 8'h44;
        chk("t4_ovf_b", {7'd0, overflow}, 8'd0);
        tick();
        in_byte = 8'h55;
        chk("t4_notfull", {7'd0, fifo_full}, 8'd0);
        tick();
        in_stb = 1'b0;
        chk("t4_full", {7'd0, fifo_full}, 8'd1);
        chk("t4_ovf_c", {7'd0, overflow}, 8'd0);
        tick();
        chk("t4_ovf_d", {7'd0, overflow}, 8'd0);
      end
      begin
        tick(); tick();
        check_frame(8'h11, "t4"); gap("t4");
        check_frame(8'h22, "t4"); gap("t4");
        check_frame(8'h33, "t4"); gap("t4");
        check_frame(8'h3C, "t4"); gap("t4");
        check_frame(8'h44, "t4"); gap("t4");
        check_frame(8'h55, "t4");
        chk("t4_end_busy", {7'd0, busy}, 8'd0);
      end
    join

    // 5: reset in the middle of a data bit with two bytes queued
    in_stb = 1'b1; in_byte = 8'hFF; tick();
    in_byte = 8'hAA; tick();
    in_byte = 8'hBB; tick();
    in_stb = 1'b0;
    repeat (27) tick();
    chk("t5_mid_tx", {7'd0, tx}, 8'd1);
    chk("t5_mid_busy", {7'd0, busy}, 8'd1);
    repeat (11) tick();
    chk("t5_bit_tx", {7'd0, tx}, 8'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx", {7'd0, tx}, 8'd1);
    chk("t5_rst_busy", {7'd0, busy}, 8'd0);
    chk("t5_rst_full", {7'd0, fifo_full}, 8'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      chk("t5_quiet_tx", {7'd0, tx}, 8'd1);
      chk("t5_quiet_busy", {7'd0, busy}, 8'd0);
    end

    // 6: all-zero then all-one frames back to back
    in_stb = 1'b1; in_byte = 8'h00; tick();
    in_byte = 8'hFF; tick();
    in_stb = 1'b0; in_byte = 8'h00;
    check_frame(8'h00, "t6");
    gap("t6");
    check_frame(8'hFF, "t6");
    chk("t6_end_busy", {7'd0, busy}, 8'd0);
    chk("t6_end_tx", {7'd0, tx}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
